// File: rtl/fb_access_arbiter.sv
// Framebuffer port sharing: video scan-out reads always win, game-logic writers
// round-robin through every remaining cycle. RAM-side signals are registered.
module fb_access_arbiter #(
   parameter int H_RES            = 640,
   parameter int SCALE_SH         = 2,
   parameter int ADDR_W           = 15,
   parameter int DATA_W           = 8,
   parameter int NUM_WR           = 4,
   parameter int WR_ONLY_IN_BLANK = 0
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic                     i_pix_stb,
   input  logic                     i_active,
   input  logic [9:0]               i_x,
   input  logic [8:0]               i_y,
   input  logic [NUM_WR-1:0]        i_wr_req,
   input  logic [NUM_WR*ADDR_W-1:0] i_wr_addr,
   input  logic [NUM_WR*DATA_W-1:0] i_wr_data,
   output logic [NUM_WR-1:0]        o_wr_gnt,
   output logic                     o_mem_en,
   output logic                     o_mem_we,
   output logic [ADDR_W-1:0]        o_mem_addr,
   output logic [DATA_W-1:0]        o_mem_wdata,
   input  logic [DATA_W-1:0]        i_mem_rdata,
   output logic [DATA_W-1:0]        o_pix,
   output logic                     o_pix_valid
);
   localparam int PTR_W  = (NUM_WR > 1) ? $clog2(NUM_WR) : 1;
   localparam int CALC_W = ADDR_W + 11;
   localparam int STAGES = 2;
   localparam logic [CALC_W-1:0] LINE_W = CALC_W'(H_RES >> SCALE_SH);

   logic                 vid;
   logic                 wr_ok;
   logic                 win_found;
   logic [PTR_W-1:0]     win_idx;
   logic [PTR_W-1:0]     ptr;
   logic [CALC_W-1:0]    vaddr_full;
   logic [STAGES:1]      vld_pipe;
   logic [STAGES:1]      vid_pipe;
   logic [DATA_W-1:0]    pix_hold;

   function automatic logic [PTR_W-1:0] rr_idx(input logic [PTR_W-1:0] p, input int off);
      return PTR_W'((int'(p) + off) % NUM_WR);
   endfunction

   assign vid        = i_pix_stb & i_active;
   assign vaddr_full = CALC_W'(i_y >> SCALE_SH) * LINE_W + CALC_W'(i_x >> SCALE_SH);
   assign wr_ok      = ~i_rst & ~vid & ~((WR_ONLY_IN_BLANK != 0) & i_active);

   // Scan from ptr upward with wrap; first requester found wins.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      o_wr_gnt  = '0;
      for (int i = 0; i < NUM_WR; i++) begin
         if (wr_ok && !win_found && i_wr_req[rr_idx(ptr, i)]) begin
            win_found = 1'b1;
            win_idx   = rr_idx(ptr, i);
         end
      end
      if (win_found) o_wr_gnt[win_idx] = 1'b1;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         ptr         <= '0;
         o_mem_en    <= 1'b0;
         o_mem_we    <= 1'b0;
         o_mem_addr  <= '0;
         o_mem_wdata <= '0;
         vld_pipe    <= '0;
         vid_pipe    <= '0;
         pix_hold    <= '0;
      end else begin
         if (vid) begin
            o_mem_en   <= 1'b1;
            o_mem_we   <= 1'b0;
            o_mem_addr <= vaddr_full[ADDR_W-1:0];
         end else if (win_found) begin
            o_mem_en    <= 1'b1;
            o_mem_we    <= 1'b1;
            o_mem_addr  <= i_wr_addr[win_idx*ADDR_W +: ADDR_W];
            o_mem_wdata <= i_wr_data[win_idx*DATA_W +: DATA_W];
            ptr         <= rr_idx(win_idx, 1);
         end else begin
            o_mem_en <= 1'b0;
            o_mem_we <= 1'b0;
         end
         vld_pipe <= {vld_pipe[STAGES-1:1], i_pix_stb};
         vid_pipe <= {vid_pipe[STAGES-1:1], i_active};
         pix_hold <= o_pix;
      end
   end

   // Read data arrives combinationally in the last stage; hold it otherwise.
   always_comb begin
      o_pix = pix_hold;
      if (vld_pipe[STAGES]) o_pix = vid_pipe[STAGES] ? i_mem_rdata : '0;
   end

   assign o_pix_valid = vld_pipe[STAGES];
endmodule

// File: tb/tb_fb_access_arbiter.sv
// Scoreboard bench: stimulus pushes expected grants, RAM transactions and pixels;
// a negedge monitor pops and compares whenever the DUT presents them.
module tb_fb_access_arbiter;
   localparam int AW = 15;
   localparam int DW = 8;
   localparam int NW = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic           rst, stb, active;
   logic [9:0]     x;
   logic [8:0]     y;
   logic [NW-1:0]  req, gnt;
   logic [NW*AW-1:0] waddr;
   logic [NW*DW-1:0] wdata;
   logic           mem_en, mem_we, pix_valid;
   logic [AW-1:0]  mem_addr;
   logic [DW-1:0]  mem_wdata, rdata, pix;

   logic           b_active;
   logic [NW-1:0]  b_req, b_gnt;
   logic [NW*AW-1:0] b_waddr;
   logic [NW*DW-1:0] b_wdata;
   logic           b_mem_en, b_mem_we, b_pix_valid;
   logic [AW-1:0]  b_mem_addr;
   logic [DW-1:0]  b_mem_wdata, b_pix;
   logic [DW-1:0]  b_rdata = '0;
   logic           b_stb = 1'b0;

   fb_access_arbiter dut (
      .i_clk(clk), .i_rst(rst), .i_pix_stb(stb), .i_active(active), .i_x(x), .i_y(y),
      .i_wr_req(req), .i_wr_addr(waddr), .i_wr_data(wdata), .o_wr_gnt(gnt),
      .o_mem_en(mem_en), .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
      .i_mem_rdata(rdata), .o_pix(pix), .o_pix_valid(pix_valid));

   fb_access_arbiter #(.WR_ONLY_IN_BLANK(1)) dut_b (
      .i_clk(clk), .i_rst(rst), .i_pix_stb(b_stb), .i_active(b_active), .i_x(10'd0), .i_y(9'd0),
      .i_wr_req(b_req), .i_wr_addr(b_waddr), .i_wr_data(b_wdata), .o_wr_gnt(b_gnt),
      .o_mem_en(b_mem_en), .o_mem_we(b_mem_we), .o_mem_addr(b_mem_addr), .o_mem_wdata(b_mem_wdata),
      .i_mem_rdata(b_rdata), .o_pix(b_pix), .o_pix_valid(b_pix_valid));

   // single-port RAM model
   logic [DW-1:0] ram [0:(1<<AW)-1];
   always @(posedge clk)
      if (mem_en) begin
         if (mem_we) ram[mem_addr] <= mem_wdata;
         else        rdata <= ram[mem_addr];
      end

   int n_chk = 0;
   int n_pass = 0;
   logic [NW-1:0] gq[$];
   logic [23:0]   mq[$];
   logic [DW-1:0] pq[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
   endtask

   always @(negedge clk) begin
      if (gnt != '0) begin
         if (gq.size() == 0) chk("gnt_unexpected", 32'(gnt), 32'h0);
         else                chk("gnt", 32'(gnt), 32'(gq.pop_front()));
      end
      if (mem_en === 1'b1) begin
         if (mq.size() == 0) chk("mem_unexpected", {8'h0, mem_we, mem_addr, mem_wdata}, 32'h0);
         else                chk("mem_we_addr_wdata", {8'h0, mem_we, mem_addr, mem_wdata}, 32'(mq.pop_front()));
      end
      if (pix_valid === 1'b1) begin
         if (pq.size() == 0) chk("pix_unexpected", 32'(pix), 32'hFFFF);
         else                chk("pix", 32'(pix), 32'(pq.pop_front()));
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_mem(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
      mq.push_back({we, a, d});
   endtask

   logic [AW-1:0] ta [NW] = '{15'd100, 15'd101, 15'd162, 15'd19199};
   logic [DW-1:0] td [NW] = '{8'h11, 8'h22, 8'hA5, 8'h44};

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < (1 << AW); i++) ram[i] = '0;
      for (int k = 0; k < NW; k++) begin
         waddr[k*AW +: AW] = ta[k];
         wdata[k*DW +: DW] = td[k];
         b_waddr[k*AW +: AW] = AW'(70 + k * 7);
         b_wdata[k*DW +: DW] = DW'(8'h50 + 8'(k * 5));
      end
      rst = 1'b1; stb = 1'b0; active = 1'b0; x = '0; y = '0;
      req = '1; b_req = '1; b_active = 1'b0;

      // reset with every request raised
      step(); step();
      @(negedge clk);
      chk("rst_gnt", 32'(gnt), 32'h0);
      chk("rst_mem_en", 32'(mem_en), 32'h0);
      chk("rst_pix_valid", 32'(pix_valid), 32'h0);
      chk("rst_b_gnt", 32'(b_gnt), 32'h0);
      step();
      rst = 1'b0; b_req = '0;

      // all four held: strict rotation
      for (int i = 0; i < 5; i++) begin
         gq.push_back(NW'(1 << (i % NW)));
         push_mem(1'b1, ta[i % NW], td[i % NW]);
         step();
      end

      // video at x=8,y=4 with req0 up: read 162 first, write next cycle
      stb = 1'b1; active = 1'b1; x = 10'd8; y = 9'd4; req = 4'b0001;
      push_mem(1'b0, 15'd162, 8'h11);
      pq.push_back(8'hA5);
      @(negedge clk);
      chk("gnt_video_blocks", 32'(gnt), 32'h0);
      step();
      stb = 1'b0; active = 1'b0;
      gq.push_back(4'b0001);
      push_mem(1'b1, 15'd100, 8'h11);
      step();
      req = '0;

      // blanking strobe gives a zero pixel
      stb = 1'b1; active = 1'b0;
      pq.push_back(8'h00);
      step();
      stb = 1'b0;
      step();

      // back-to-back video, last pixel of the frame then x=404,y=3
      stb = 1'b1; active = 1'b1; x = 10'd639; y = 9'd479;
      push_mem(1'b0, 15'd19199, 8'h11);
      pq.push_back(8'h44);
      step();
      x = 10'd404; y = 9'd3;
      push_mem(1'b0, 15'd101, 8'h11);
      pq.push_back(8'h22);
      step();
      stb = 1'b0; active = 1'b0;
      step(); step();

      // reset right after a video read: no pixel, pointer back to 0
      stb = 1'b1; active = 1'b1; x = 10'd0; y = 9'd0;
      push_mem(1'b0, 15'd0, 8'h11);
      step();
      stb = 1'b0; active = 1'b0; rst = 1'b1;
      step(); step();
      rst = 1'b0; req = 4'b1001;
      gq.push_back(4'b0001);
      push_mem(1'b1, 15'd100, 8'h11);
      step();
      req = '0;
      step(); step(); step();

      // blank-only writes: held off through active video
      b_active = 1'b1; b_req = 4'b0100;
      @(negedge clk);
      chk("b_gnt_active", 32'(b_gnt), 32'h0);
      step();
      @(negedge clk);
      chk("b_gnt_active2", 32'(b_gnt), 32'h0);
      chk("b_mem_en_active", 32'(b_mem_en), 32'h0);
      step();
      b_active = 1'b0;
      @(negedge clk);
      chk("b_gnt_blank", 32'(b_gnt), 32'h4);
      step();
      b_req = '0;
      @(negedge clk);
      chk("b_mem_write", {8'h0, b_mem_en, b_mem_we, b_mem_addr, b_mem_wdata}, {8'h0, 2'b11, 15'd84, 8'h5A});
      step(); step();

      chk("gq_drained", 32'(gq.size()), 32'h0);
      chk("mq_drained", 32'(mq.size()), 32'h0);
      chk("pq_drained", 32'(pq.size()), 32'h0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
